wb_copy_master: RTL
===================

# wb_copy_master

Wishbone classic-cycle initiator that copies a block of words from one address range to another over a single Wishbone master port. It sits between a control register block (or CPU-side command interface) and any of the team's Wishbone RAM responders, using a registered-ack responder as its fastest target. Each word is moved as one read access followed by one write access. Completion and an optional watchdog error are reported with a single-cycle done pulse.

## Interface
- DATA_WIDTH, 32: Wishbone data width in bits (8, 16, 32, 64).
- ADDR_WIDTH, 16: Wishbone byte-address width.
- SELECT_WIDTH, DATA_WIDTH/8: byte-select width; address stride per word = SELECT_WIDTH.
- LEN_WIDTH, 16: width of the word-count input.
- TIMEOUT_CYCLES, 255: watchdog limit in cycles; used only with WB_COPY_TIMEOUT_EN; range 1..65535.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  command strobe; sampled only in IDLE.
- src_adr  in  ADDR_WIDTH  source byte address; low log2(SELECT_WIDTH) bits ignored (treated as 0).
- dst_adr  in  ADDR_WIDTH  destination byte address; same alignment rule.
- len  in  LEN_WIDTH  number of words to copy; 0 is legal.
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; 1 = aborted by watchdog.
- m_adr_o  out  ADDR_WIDTH  Wishbone address.
- m_dat_o  out  DATA_WIDTH  write data.
- m_dat_i  in  DATA_WIDTH  read data.
- m_we_o  out  1  write enable.
- m_sel_o  out  SELECT_WIDTH  byte selects; all ones during every access.
- m_stb_o  out  1  strobe.
- m_cyc_o  out  1  cycle.
- m_ack_i  in  1  acknowledge.

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE: start=1 with len!=0 → latch src/dst (aligned), count=len; enter READ. start=1 with len=0 → DONE, no bus activity. start=0 → stay.
- READ: cyc=stb=1, we=0, adr=src. On ack: capture m_dat_i into data register; go WRITE.
- WRITE: cyc=stb=1, we=1, adr=dst, m_dat_o=data register. On ack: src+=SELECT_WIDTH, dst+=SELECT_WIDTH, count-=1; count reaching 0 → DONE, else READ.
- DONE: done=1 for exactly one cycle, cyc=stb=0, then IDLE.
- Address increment wraps modulo 2**ADDR_WIDTH; no error on wrap.
- Overlapping ranges are not detected; copy is strictly ascending.
- start while busy is ignored; src/dst/len changes while busy have no effect.
- err is cleared on each accepted start and holds until the next accepted start.

## Timing
- Reset: busy=0, done=0, err=0, m_cyc_o=0, m_stb_o=0, m_we_o=0, m_adr_o=0, m_dat_o=0, m_sel_o=0; state IDLE.
- All outputs registered.
- Reset asserted mid-transfer: cyc/stb drop at that edge; no done pulse.
- m_cyc_o stays high continuously from the first READ to the last WRITE ack, including READ↔WRITE transitions.
- ack is sampled at a clock edge. At that same edge the next access's address, we, and data are presented with stb kept high. The responder must not re-ack on the stale ack cycle.
- With a registered-ack responder: 2 cycles per access, 4 cycles per word. Start→done = 4·len+2 cycles for len≥1; 2 cycles for len=0.
- m_ack_i is ignored in IDLE and DONE.

## Configuration
- WB_COPY_TIMEOUT_EN defined: a counter clears at each access start and increments each cycle stb=1 without ack. Reaching TIMEOUT_CYCLES → cyc/stb drop, go DONE with err=1, remaining words skipped.
- Macro undefined: no counter; the block waits indefinitely for ack; err tied 0.

## Test plan
- Copy src=0x0000, dst=0x0100, len=4 into RAM preloaded 0x11111111..0x44444444 → dst words match, done after 18 cycles, err=0, cyc high continuously.
- len=0, start=1 → done 2 cycles later, cyc never asserted, busy=1 for one cycle only.
- src=0x0003 (DATA_WIDTH=32) → first read at 0x0000; dst=0xFFFC with len=2 → second write at 0x0000 (wrap).
- start pulsed again mid-copy with different len → ignored, original word count completed.
- rst_n=0 during the WRITE of word 2 → cyc/stb low next edge, busy=0, no done; a new start afterward runs normally.
- WB_COPY_TIMEOUT_EN, TIMEOUT_CYCLES=8, responder never acks → stb high 8 cycles, then done=1, err=1, busy=0.

Source files
------------

// File: rtl/wb_copy_if.sv
// wb_copy_if: Wishbone classic-cycle bus bundle between a copy initiator and
// a memory responder.
//
// Signals (named from the initiator's point of view):
//   m_adr_o  ADDR_WIDTH    byte address
//   m_dat_o  DATA_WIDTH    write data
//   m_dat_i  DATA_WIDTH    read data
//   m_we_o   1             write enable
//   m_sel_o  SELECT_WIDTH  byte selects
//   m_stb_o  1             strobe
//   m_cyc_o  1             cycle
//   m_ack_i  1             acknowledge
//
// Modports: master (initiator side), slave (responder side).
interface wb_copy_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8
);
  logic [ADDR_WIDTH-1:0]   m_adr_o;
  logic [DATA_WIDTH-1:0]   m_dat_o;
  logic [DATA_WIDTH-1:0]   m_dat_i;
  logic                    m_we_o;
  logic [SELECT_WIDTH-1:0] m_sel_o;
  logic                    m_stb_o;
  logic                    m_cyc_o;
  logic                    m_ack_i;

  modport master (
    output m_adr_o, m_dat_o, m_we_o, m_sel_o, m_stb_o, m_cyc_o,
    input  m_dat_i, m_ack_i
  );

  modport slave (
    input  m_adr_o, m_dat_o, m_we_o, m_sel_o, m_stb_o, m_cyc_o,
    output m_dat_i, m_ack_i
  );
endinterface

// File: rtl/wb_copy_master.sv
// wb_copy_master: Wishbone classic-cycle initiator that copies len words from
// src_adr to dst_adr, one read access followed by one write access per word,
// strictly ascending addresses with wrap modulo 2**ADDR_WIDTH.
//
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   start         command strobe, only sampled in IDLE
//   src_adr       source byte address (low alignment bits ignored)
//   dst_adr       destination byte address (low alignment bits ignored)
//   len           word count, 0 is legal (done pulse, no bus activity)
//   busy          high from the cycle after an accepted start until done
//   done          one-cycle completion pulse
//   err           valid with done; 1 = aborted by watchdog; held until next start
//   dbg_state     current FSM state (IDLE=0, READ=1, WRITE=2, DONE=3)
//   m             Wishbone master port (wb_copy_if.master)
//
// Optional feature macro: WB_COPY_TIMEOUT_EN enables a per-access watchdog of
// TIMEOUT_CYCLES cycles. Without it the block waits indefinitely for ack and
// err never rises.
//
// Handshake: an access is in progress while m_cyc_o && m_stb_o are high; it
// completes at the rising edge where m_ack_i is sampled high. At that same
// edge the next access (address, we, data) is presented with stb kept high,
// so the responder must not acknowledge again in the cycle its stale ack is
// still visible. All outputs are registered.
module wb_copy_master #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 16,
  parameter int SELECT_WIDTH   = DATA_WIDTH / 8,
  parameter int LEN_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_adr,
  input  logic [ADDR_WIDTH-1:0] dst_adr,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [1:0]            dbg_state,
  wb_copy_if.master             m
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] STRIDE     = ADDR_WIDTH'(SELECT_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(SELECT_WIDTH - 1));

  state_t                state;
  logic [ADDR_WIDTH-1:0] src_q;
  logic [ADDR_WIDTH-1:0] dst_q;
  logic [LEN_WIDTH-1:0]  count_q;

  assign dbg_state = state;

`ifdef WB_COPY_TIMEOUT_EN
  logic [15:0] wd_cnt;
  logic        wd_expire;

  // Fires on the edge that would complete the TIMEOUT_CYCLES-th unacked
  // strobe cycle, so stb is high for exactly TIMEOUT_CYCLES cycles.
  assign wd_expire = m.m_stb_o && !m.m_ack_i && (wd_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT_CYCLES);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      src_q     <= '0;
      dst_q     <= '0;
      count_q   <= '0;
      m.m_adr_o <= '0;
      m.m_dat_o <= '0;
      m.m_we_o  <= 1'b0;
      m.m_sel_o <= '0;
      m.m_stb_o <= 1'b0;
      m.m_cyc_o <= 1'b0;
`ifdef WB_COPY_TIMEOUT_EN
      wd_cnt    <= '0;
`endif
    end else begin
      done <= 1'b0;

`ifdef WB_COPY_TIMEOUT_EN
      // Restart at every access boundary (ack) and whenever the bus is idle.
      if (m.m_stb_o && !m.m_ack_i) wd_cnt <= wd_cnt + 16'd1;
      else                         wd_cnt <= '0;
`endif

      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            err  <= 1'b0;
            if (len == '0) begin
              state <= DONE;
            end else begin
              src_q     <= src_adr & ALIGN_MASK;
              dst_q     <= dst_adr & ALIGN_MASK;
              count_q   <= len;
              m.m_adr_o <= src_adr & ALIGN_MASK;
              m.m_we_o  <= 1'b0;
              m.m_sel_o <= '1;
              m.m_stb_o <= 1'b1;
              m.m_cyc_o <= 1'b1;
              state     <= READ;
            end
          end
        end

        READ: begin
          if (m.m_ack_i) begin
            // m_dat_o doubles as the data holding register.
            m.m_dat_o <= m.m_dat_i;
            m.m_adr_o <= dst_q;
            m.m_we_o  <= 1'b1;
            state     <= WRITE;
          end
        end

        WRITE: begin
          if (m.m_ack_i) begin
            src_q   <= src_q + STRIDE;
            dst_q   <= dst_q + STRIDE;
            count_q <= count_q - 1'b1;
            if (count_q == LEN_WIDTH'(1)) begin
              m.m_we_o  <= 1'b0;
              m.m_sel_o <= '0;
              m.m_stb_o <= 1'b0;
              m.m_cyc_o <= 1'b0;
              state     <= DONE;
            end else begin
              // cyc/stb stay high straight into the next read.
              m.m_adr_o <= src_q + STRIDE;
              m.m_we_o  <= 1'b0;
              state     <= READ;
            end
          end
        end

        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase

`ifdef WB_COPY_TIMEOUT_EN
      // Abort overrides the (ack-less, hence inactive) READ/WRITE branches.
      if ((state == READ || state == WRITE) && wd_expire) begin
        m.m_we_o  <= 1'b0;
        m.m_sel_o <= '0;
        m.m_stb_o <= 1'b0;
        m.m_cyc_o <= 1'b0;
        err       <= 1'b1;
        state     <= DONE;
      end
`endif
    end
  end

endmodule
